// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared operation and state types for the digit-serial adder/subtractor
package addsub_pkg;

   typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} addsub_op_t;

   typedef enum logic {S_IDLE, S_BUSY} addsub_state_t;

endpackage

// File: rtl/addsub_chunk.sv
// rtl/addsub_chunk.sv - combinational CHUNK-bit ripple-carry adder slice
module addsub_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic c;

   always_comb begin
      s = '0;
      c = cin;
      for (int i = 0; i < CHUNK; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial two's-complement add/sub with start/busy/done handshake
module addsub_serial
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             Cf,
   output logic             Sf,
   output logic             Of,
   output logic             Zf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

   addsub_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cf_q, cf_d, sf_q, sf_d, of_q, of_d, zf_q, zf_d;
   logic             done_q, done_d;

   logic [CHUNK-1:0] chunk_s;
   logic             chunk_cout;
   logic [WIDTH-1:0] sum_full;

   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x    (a_q[CHUNK-1:0]),
      .y    (opb_q[CHUNK-1:0]),
      .cin  (carry_q),
      .s    (chunk_s),
      .cout (chunk_cout)
   );

   // New chunk enters at the top; after the last chunk the register holds the full sum.
   assign sum_full = (part_q >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      a_d      = a_q;
      opb_d    = opb_q;
      part_d   = part_q;
      result_d = result_q;
      cf_d     = cf_q;
      sf_d     = sf_q;
      of_d     = of_q;
      zf_d     = zf_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               opb_d   = (op == OP_SUB) ? ~b : b;
               carry_d = op;
               cnt_d   = '0;
               part_d  = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            a_d     = a_q >> CHUNK;
            opb_d   = opb_q >> CHUNK;
            part_d  = sum_full;
            carry_d = chunk_cout;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               // Only the top chunk remains in the operand registers, so their MSBs are at CHUNK-1.
               result_d = sum_full;
               cf_d     = chunk_cout;
               sf_d     = chunk_s[CHUNK-1];
               of_d     = (a_q[CHUNK-1] == opb_q[CHUNK-1]) && (chunk_s[CHUNK-1] != a_q[CHUNK-1]);
               zf_d     = (sum_full == '0);
               done_d   = 1'b1;
               cnt_d    = '0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         opb_q    <= '0;
         part_q   <= '0;
         result_q <= '0;
         cf_q     <= 1'b0;
         sf_q     <= 1'b0;
         of_q     <= 1'b0;
         zf_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         opb_q    <= opb_d;
         part_q   <= part_d;
         result_q <= result_d;
         cf_q     <= cf_d;
         sf_q     <= sf_d;
         of_q     <= of_d;
         zf_q     <= zf_d;
         done_q   <= done_d;
      end
   end

   assign busy   = (state_q == S_BUSY);
   assign done   = done_q;
   assign result = result_q;
   assign Cf     = cf_q;
   assign Sf     = sf_q;
   assign Of     = of_q;
   assign Zf     = zf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - directed self-checking bench for addsub_serial (WIDTH=32, CHUNK=8)
module tb_addsub_serial;

   logic        clk = 1'b0;
   logic        rst, start, op;
   logic [31:0] a, b;
   logic        busy, done, Cf, Sf, Of, Zf;
   logic [31:0] result;

   int n_checks = 0;
   int n_fails  = 0;

   addsub_serial #(.WIDTH(32), .CHUNK(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .Cf     (Cf),
      .Sf     (Sf),
      .Of     (Of),
      .Zf     (Zf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // lat counts edges from the start edge (inclusive) to the first cycle with done high.
   task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int busy_cyc);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; op = ~o; a = $urandom; b = $urandom;
      lat = 1; busy_cyc = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cyc++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   int  lat, bcyc, seen;

   initial begin
      rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      #12;
      check("rst_busy",   {31'b0, busy}, 32'd0);
      check("rst_done",   {31'b0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_flags",  {28'b0, Cf, Sf, Of, Zf}, 32'd0);
      @(negedge clk); rst = 1'b0;

      // 1: 5 - 3
      do_op(1'b1, 32'd5, 32'd3, lat, bcyc);
      check("t1_lat",    lat, 32'd5);
      check("t1_busy",   bcyc, 32'd4);
      check("t1_result", result, 32'h0000_0002);
      check("t1_flags",  {28'b0, Cf, Sf, Of, Zf}, 32'b1000);
      @(posedge clk); #1;
      check("t1_done_pulse", {31'b0, done}, 32'd0);
      check("t1_hold",   result, 32'h0000_0002);

      // 2: 3 - 5
      do_op(1'b1, 32'd3, 32'd5, lat, bcyc);
      check("t2_result", result, 32'hFFFF_FFFE);
      check("t2_flags",  {28'b0, Cf, Sf, Of, Zf}, 32'b0100);

      // 3: carry ripples across every chunk
      do_op(1'b0, 32'h7FFF_FFFF, 32'd1, lat, bcyc);
      check("t3_result", result, 32'h8000_0000);
      check("t3_flags",  {28'b0, Cf, Sf, Of, Zf}, 32'b0110);

      // 4: signed underflow, then unsigned wrap to zero
      do_op(1'b1, 32'h8000_0000, 32'd1, lat, bcyc);
      check("t4a_result", result, 32'h7FFF_FFFF);
      check("t4a_flags",  {28'b0, Cf, Sf, Of, Zf}, 32'b1010);
      do_op(1'b0, 32'hFFFF_FFFF, 32'd1, lat, bcyc);
      check("t4b_result", result, 32'h0000_0000);
      check("t4b_flags",  {28'b0, Cf, Sf, Of, Zf}, 32'b1001);
      do_op(1'b1, 32'd0, 32'd0, lat, bcyc);
      check("t4c_result", result, 32'h0000_0000);
      check("t4c_flags",  {28'b0, Cf, Sf, Of, Zf}, 32'b1001);

      // 5: start while busy is ignored; start in the done cycle is accepted
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; start = 1'b1; op = 1'b1; a = 32'hFFFF_FFFF; b = 32'd0;
      @(posedge clk); #1; start = 1'b0;
      lat = 3;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("t5_lat",    lat, 32'd5);
      check("t5_result", result, 32'h2345_6789);
      check("t5_flags",  {28'b0, Cf, Sf, Of, Zf}, 32'b0000);
      start = 1'b1; op = 1'b1; a = 32'h0000_0100; b = 32'd1;
      @(posedge clk); #1; start = 1'b0;
      check("t5_b2b_busy", {31'b0, busy}, 32'd1);
      check("t5_done_clr", {31'b0, done}, 32'd0);
      lat = 1;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("t5_b2b_lat",    lat, 32'd5);
      check("t5_b2b_result", result, 32'h0000_00FF);
      check("t5_b2b_flags",  {28'b0, Cf, Sf, Of, Zf}, 32'b1000);

      // 6: asynchronous reset mid-operation
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'h0000_00FF; b = 32'd1;
      @(posedge clk); #1; start = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("t6_rst_busy",   {31'b0, busy}, 32'd0);
      check("t6_rst_done",   {31'b0, done}, 32'd0);
      check("t6_rst_result", result, 32'd0);
      check("t6_rst_flags",  {28'b0, Cf, Sf, Of, Zf}, 32'd0);
      @(negedge clk); rst = 1'b0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1;
      end
      check("t6_no_done", seen, 32'd0);
      do_op(1'b1, 32'd10, 32'd10, lat, bcyc);
      check("t6_lat",    lat, 32'd5);
      check("t6_result", result, 32'h0000_0000);
      check("t6_flags",  {28'b0, Cf, Sf, Of, Zf}, 32'b1001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
